comparador_serial_ctrl: RTL and testbench

Sequential, bit-serial controller for the right-to-left A-versus-B comparison datapath. It captures two N-bit words on a start request and steps the single comparison cell through the bits one per clock, LSB first. It then reports Zout = 1 when A <= B and Zout = 0 when A > B, with a busy/done handshake. It replaces the fully unrolled iterative network wherever area matters more than latency, and it presents the same A/B/Zout semantics to the surrounding logic.

---
 rtl/comparador_pkg.sv | 17 +
 rtl/comparador_serial_ctrl_celda.sv | 18 +
 rtl/comparador_serial_ctrl.sv | 90 +++++++++
 tb/tb_comparador_serial_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared definitions for the comparator cell and its bit-serial controller.
package comparador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Carry start value: equal words must resolve to A <= B.
   localparam logic Z_INIT = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/comparador_serial_ctrl_celda.sv
// Single right-to-left comparison cell: a higher bit that differs overrides the incoming carry.
module celda_comparador (
   input  logic z_in,
   input  logic a,
   input  logic b,
   output logic z_out
);

   always_comb begin
      z_out = z_in;
      if (a && !b) begin
         z_out = 1'b0;
      end else if (!a && b) begin
         z_out = 1'b1;
      end
   end

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial A <= B comparator: captures A/B on start, walks one cell LSB first, pulses done.
module comparador_serial_ctrl
   import comparador_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         Zout
);

   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        r_state;
   logic [N-1:0]  r_sa;
   logic [N-1:0]  r_sb;
   logic [CW-1:0] r_cnt;
   logic          r_z;
   logic          r_zout;
   logic          r_busy;
   logic          r_done;
   logic          w_z_next;

   celda_comparador u_celda (
      .z_in  (r_z),
      .a     (r_sa[0]),
      .b     (r_sb[0]),
      .z_out (w_z_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sa    <= '0;
         r_sb    <= '0;
         r_cnt   <= '0;
         r_z     <= Z_INIT;
         r_zout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_sa    <= A;
                  r_sb    <= B;
                  r_z     <= Z_INIT;
                  r_cnt   <= '0;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            RUN: begin
               r_z  <= w_z_next;
               r_sa <= r_sa >> 1;
               r_sb <= r_sb >> 1;
               // Counter holds on the last bit so it never wraps for power-of-two N.
               if (r_cnt == LAST) begin
                  r_state <= DONE;
                  r_zout  <= w_z_next;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign Zout = r_zout;

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Randomized and directed checks of the bit-serial comparator against an arithmetic A <= B model.
module tb_comparador_serial_ctrl;

   localparam int unsigned N = 3;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic         Zout;

   int unsigned n_vec;
   int unsigned n_err;
   int unsigned neg_cnt;
   logic        exp_z;

   comparador_serial_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Zout  (Zout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial neg_cnt = 0;
   always @(negedge clk) neg_cnt <= neg_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Entered at a negedge with the DUT in IDLE or DONE; returns at the negedge where done is seen.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit hold, input bit scramble);
      int unsigned cyc;
      A = a;
      B = b;
      start = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (!done && cyc < 3 * N + 4) begin
         check_eq("busy_run", busy, 1'b1);
         check_eq("zout_hold", Zout, exp_z);
         if (!hold) start = 1'b0;
         if (scramble) begin
            A = N'($urandom);
            B = N'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      check_eq("latency", cyc, N);
      check_eq("done", done, 1'b1);
      check_eq("busy_done", busy, 1'b0);
      exp_z = (a <= b);
      check_eq("zout", Zout, exp_z);
      start = 1'b0;
   endtask

   task automatic idle_cycle();
      start = 1'b0;
      A = N'($urandom);
      B = N'($urandom);
      @(negedge clk);
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_zout", Zout, exp_z);
   endtask

   initial begin
      int unsigned t_first;
      logic [N-1:0] ra, rb;
      n_vec = 0;
      n_err = 0;
      exp_z = 1'b0;
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      #12;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_zout", Zout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();

      do_op(3'b111, 3'b111, 1'b0, 1'b0);
      idle_cycle();
      idle_cycle();
      do_op(3'b100, 3'b011, 1'b0, 1'b0);
      idle_cycle();
      do_op(3'b011, 3'b100, 1'b0, 1'b0);
      idle_cycle();
      do_op(3'b000, 3'b111, 1'b0, 1'b0);
      idle_cycle();

      // Reset mid-RUN, away from any clock edge.
      A = 3'b110;
      B = 3'b001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrun_rst_busy", busy, 1'b0);
      check_eq("midrun_rst_done", done, 1'b0);
      check_eq("midrun_rst_zout", Zout, 1'b0);
      exp_z = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
      idle_cycle();

      // Start held and operands scrambled throughout RUN.
      do_op(3'b101, 3'b100, 1'b1, 1'b1);
      idle_cycle();
      do_op(3'b010, 3'b110, 1'b1, 1'b1);
      idle_cycle();

      // Back-to-back: second start lands in the DONE cycle.
      do_op(3'b110, 3'b101, 1'b0, 1'b0);
      t_first = neg_cnt;
      do_op(3'b001, 3'b001, 1'b0, 1'b0);
      check_eq("b2b_period", neg_cnt - t_first, N + 1);
      idle_cycle();

      for (int i = 0; i < 64; i++) begin
         ra = N'(i / 8);
         rb = N'(i % 8);
         do_op(ra, rb, 1'b0, 1'b0);
         if ($urandom_range(0, 1) == 0) idle_cycle();
      end
      idle_cycle();

      for (int i = 0; i < 40; i++) begin
         do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
         for (int k = 0, g = $urandom_range(0, 2); k < g; k++) idle_cycle();
      end
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
